mvb_rr_arbiter: RTL and testbench



---
 rtl/mvb_rr_arbiter_pkg.sv | 24 ++
 rtl/mvb_rr_arbiter_pick.sv | 37 +++
 rtl/mvb_rr_arbiter.sv | 111 +++++++++++
 tb/tb_mvb_rr_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvb_rr_arbiter_pkg.sv
// Shared helpers for the MVB round-robin arbiter: index-width math and the
// flattened-bus slice offsets of each input.
package mvb_rr_arbiter_pkg;

  // Ceiling log2; callers guarantee n >= 2 so the result is at least 1.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned data_lsb(input int unsigned idx, input int unsigned regions,
                                           input int unsigned item_width);
    return idx * regions * item_width;
  endfunction

  function automatic int unsigned vld_lsb(input int unsigned idx, input int unsigned regions);
    return idx * regions;
  endfunction

endpackage

// File: rtl/mvb_rr_arbiter_pick.sv
// Combinational round-robin picker: first request strictly after last_i,
// wrapping modulo N, via a double-width rotate and a priority encoder.
module mvb_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [SW-1:0] idx_o,
  output logic          vld_o
);

  logic [2*N-1:0] dbl_rot;
  logic           found;
  int unsigned    offs;
  int unsigned    pos;

  always_comb begin
    dbl_rot = {req_i, req_i} >> (32'(last_i) + 32'd1);
    found   = 1'b0;
    offs    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && dbl_rot[k]) begin
        found = 1'b1;
        offs  = k;
      end
    end
    pos   = (32'(last_i) + 32'd1 + offs) % N;
    vld_o = found;
    idx_o = found ? SW'(pos) : '0;
    for (int unsigned k = 0; k < N; k++) begin
      gnt_o[k] = found && (pos == k);
    end
  end

endmodule

// File: rtl/mvb_rr_arbiter.sv
// Round-robin arbiter merging INPUTS MVB sources into one registered MVB
// output tagged with the source index; one whole word granted per cycle.
module mvb_rr_arbiter
  import mvb_rr_arbiter_pkg::*;
#(
  parameter int unsigned INPUTS     = 4,
  parameter int unsigned REGIONS    = 4,
  parameter int unsigned ITEM_WIDTH = 8,
  parameter              DEVICE     = "ULTRASCALE"
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic [INPUTS*REGIONS*ITEM_WIDTH-1:0] RX_DATA,
  input  logic [INPUTS*REGIONS-1:0]            RX_VLD,
  input  logic [INPUTS-1:0]                    RX_SRC_RDY,
  output logic [INPUTS-1:0]                    RX_DST_RDY,
  output logic [REGIONS*ITEM_WIDTH-1:0]        TX_DATA,
  output logic [REGIONS-1:0]                   TX_VLD,
  output logic [log2(INPUTS)-1:0]              TX_SEL,
  output logic                                 TX_SRC_RDY,
  input  logic                                 TX_DST_RDY
);

  localparam int unsigned SelWidth = log2(INPUTS);
  localparam int unsigned DataW    = REGIONS * ITEM_WIDTH;

  logic                unused_device;
  logic                free;
  logic [INPUTS-1:0]   pick_gnt;
  logic [SelWidth-1:0] pick_idx;
  logic                pick_vld;
  logic [DataW-1:0]    mux_data;
  logic [REGIONS-1:0]  mux_vld;

  logic [DataW-1:0]    tx_data_q, tx_data_d;
  logic [REGIONS-1:0]  tx_vld_q, tx_vld_d;
  logic [SelWidth-1:0] tx_sel_q, tx_sel_d;
  logic                tx_src_rdy_q, tx_src_rdy_d;
  logic [SelWidth-1:0] last_q, last_d;

  assign unused_device = (DEVICE == "ULTRASCALE");

  mvb_rr_pick #(
    .N  (INPUTS),
    .SW (SelWidth)
  ) u_pick (
    .req_i  (RX_SRC_RDY),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  assign free = !tx_src_rdy_q || TX_DST_RDY;
  // Grants are suppressed during reset so a word offered then is not lost.
  assign RX_DST_RDY = (free && !RESET) ? pick_gnt : '0;

  always_comb begin
    mux_data = '0;
    mux_vld  = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      if (pick_gnt[i]) begin
        mux_data = RX_DATA[data_lsb(i, REGIONS, ITEM_WIDTH) +: DataW];
        mux_vld  = RX_VLD[vld_lsb(i, REGIONS) +: REGIONS];
      end
    end
  end

  always_comb begin
    tx_data_d    = tx_data_q;
    tx_vld_d     = tx_vld_q;
    tx_sel_d     = tx_sel_q;
    tx_src_rdy_d = tx_src_rdy_q;
    last_d       = last_q;
    if (free) begin
      tx_src_rdy_d = 1'b0;
      if (pick_vld) begin
        last_d = pick_idx;
        // Words with no valid region are consumed but never reach the output.
        if (|mux_vld) begin
          tx_data_d    = mux_data;
          tx_vld_d     = mux_vld;
          tx_sel_d     = pick_idx;
          tx_src_rdy_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_data_q    <= '0;
      tx_vld_q     <= '0;
      tx_sel_q     <= '0;
      tx_src_rdy_q <= 1'b0;
      last_q       <= SelWidth'(INPUTS - 1);
    end else begin
      tx_data_q    <= tx_data_d;
      tx_vld_q     <= tx_vld_d;
      tx_sel_q     <= tx_sel_d;
      tx_src_rdy_q <= tx_src_rdy_d;
      last_q       <= last_d;
    end
  end

  assign TX_DATA    = tx_data_q;
  assign TX_VLD     = tx_vld_q;
  assign TX_SEL     = tx_sel_q;
  assign TX_SRC_RDY = tx_src_rdy_q;

endmodule

// File: tb/tb_mvb_rr_arbiter.sv
// Bench for mvb_rr_arbiter: directed scenarios plus a randomized run, all
// compared every cycle against a behavioural round-robin model and scoreboard.
module tb_mvb_rr_arbiter;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int W  = 8;
  localparam int DW = R * W;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [N*DW-1:0]   RX_DATA;
  logic [N*R-1:0]    RX_VLD;
  logic [N-1:0]      RX_SRC_RDY;
  logic [N-1:0]      RX_DST_RDY;
  logic [DW-1:0]     TX_DATA;
  logic [R-1:0]      TX_VLD;
  logic [1:0]        TX_SEL;
  logic              TX_SRC_RDY;
  logic              TX_DST_RDY;

  mvb_rr_arbiter #(
    .INPUTS     (N),
    .REGIONS    (R),
    .ITEM_WIDTH (W),
    .DEVICE     ("ULTRASCALE")
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .RX_DATA    (RX_DATA),
    .RX_VLD     (RX_VLD),
    .RX_SRC_RDY (RX_SRC_RDY),
    .RX_DST_RDY (RX_DST_RDY),
    .TX_DATA    (TX_DATA),
    .TX_VLD     (TX_VLD),
    .TX_SEL     (TX_SEL),
    .TX_SRC_RDY (TX_SRC_RDY),
    .TX_DST_RDY (TX_DST_RDY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: output register contents and round-robin pointer.
  bit            m_vld;
  logic [DW-1:0] m_data;
  logic [R-1:0]  m_tvld;
  int            m_sel;
  int            m_last;
  logic [R+DW-1:0] sb [N][$];
  int            wait_cnt [N];
  int            n_in, n_out, n_xfer;

  // Values sampled in the latest step, for literal checks by the caller.
  logic [N-1:0]  s_dst;
  logic          s_src;
  logic [1:0]    s_sel;
  logic [DW-1:0] s_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int i, input bit src, input logic [R-1:0] v,
                        input logic [DW-1:0] d);
    RX_SRC_RDY[i]      = src;
    RX_VLD[i*R +: R]   = v;
    RX_DATA[i*DW +: DW] = d;
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = '0;
    m_tvld = '0;
    m_sel  = 0;
    m_last = N - 1;
    for (int i = 0; i < N; i++) begin
      sb[i].delete();
      wait_cnt[i] = 0;
    end
  endtask

  // Called at a negedge with inputs already driven; checks, then advances one cycle.
  task automatic step();
    int g;
    bit free;
    logic [N-1:0] exp_dst;
    logic [R+DW-1:0] front;
    logic [R-1:0] v;
    #1;
    s_dst  = RX_DST_RDY;
    s_src  = TX_SRC_RDY;
    s_sel  = TX_SEL;
    s_data = TX_DATA;
    free = !m_vld || TX_DST_RDY;
    g = -1;
    if (free && !RESET) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (g < 0 && RX_SRC_RDY[j]) g = j;
      end
    end
    exp_dst = '0;
    if (g >= 0) exp_dst[g] = 1'b1;
    chk("rx_dst_rdy", 64'(RX_DST_RDY), 64'(exp_dst));
    chk("tx_src_rdy", 64'(TX_SRC_RDY), 64'(m_vld));
    chk("tx_data", 64'(TX_DATA), 64'(m_data));
    chk("tx_vld", 64'(TX_VLD), 64'(m_tvld));
    chk("tx_sel", 64'(TX_SEL), 64'(m_sel));
    if (!RESET && TX_SRC_RDY === 1'b1 && TX_DST_RDY) begin
      if (sb[int'(TX_SEL)].size() == 0) begin
        chk("sb_unexpected_word", 64'(TX_SEL) + 64'h100, 64'(TX_SEL));
      end else begin
        front = sb[int'(TX_SEL)].pop_front();
        chk("sb_word", 64'({TX_VLD, TX_DATA}), 64'(front));
        n_out++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!RX_SRC_RDY[i] || RESET) wait_cnt[i] = 0;
      else if (g == i) begin
        chk("wait_bound_exceeded", 64'(wait_cnt[i] > N - 1), 64'd0);
        wait_cnt[i] = 0;
      end else if (g >= 0) wait_cnt[i]++;
    end
    @(posedge CLK);
    if (RESET) model_reset();
    else if (free) begin
      m_vld = 1'b0;
      if (g >= 0) begin
        n_xfer++;
        m_last = g;
        v = RX_VLD[g*R +: R];
        if (v != '0) begin
          m_vld  = 1'b1;
          m_data = RX_DATA[g*DW +: DW];
          m_tvld = v;
          m_sel  = g;
          sb[g].push_back({v, RX_DATA[g*DW +: DW]});
          n_in++;
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    chk("reset_gates_grant", 64'(s_dst), 64'd0);
    RESET = 1'b0;
  endtask

  task automatic all_idle();
    for (int i = 0; i < N; i++) set_in(i, 1'b0, 4'hF, 32'hA0A0A0A0 + 32'(i));
  endtask

  initial begin
    RESET = 1'b1;
    TX_DST_RDY = 1'b1;
    RX_SRC_RDY = '0;
    RX_VLD = '0;
    RX_DATA = '0;
    n_in = 0; n_out = 0; n_xfer = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    model_reset();
    chk("reset_tx_src_rdy", 64'(TX_SRC_RDY), 64'd0);
    chk("reset_tx_sel", 64'(TX_SEL), 64'd0);
    chk("reset_tx_data", 64'({TX_VLD, TX_DATA}), 64'd0);
    RESET = 1'b0;

    // All inputs request with output always ready: strict rotation 0,1,2,3.
    all_idle();
    for (int i = 0; i < N; i++) RX_SRC_RDY[i] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t1_grant", 64'(s_dst), 64'd1 << (k % 4));
      if (k > 0) begin
        chk("t1_sel", 64'(s_sel), 64'((k - 1) % 4));
        chk("t1_data", 64'(s_data), 64'(32'hA0A0A0A0 + 32'((k - 1) % 4)));
      end
    end

    // Single requester (input 2): granted every cycle, no gaps.
    do_reset();
    all_idle();
    for (int k = 1; k <= 6; k++) begin
      if (k <= 5) set_in(2, 1'b1, 4'hF, 32'h01010101 * 32'(k));
      else set_in(2, 1'b0, 4'hF, 32'h0);
      step();
      if (k <= 5) chk("t2_grant", 64'(s_dst), 64'h4);
      if (k >= 2) begin
        chk("t2_src_rdy", 64'(s_src), 64'd1);
        chk("t2_sel", 64'(s_sel), 64'd2);
        chk("t2_data", 64'(s_data), 64'(32'h01010101 * 32'(k - 1)));
      end
    end

    // Backpressure toggling: held cycles grant nothing, order preserved.
    do_reset();
    all_idle();
    for (int i = 0; i < N; i++) RX_SRC_RDY[i] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      TX_DST_RDY = (k % 2 == 0);
      step();
      if (k % 2 == 1) chk("t3_held_no_grant", 64'(s_dst), 64'd0);
      else chk("t3_grant", 64'(s_dst), 64'd1 << (k / 2));
    end
    TX_DST_RDY = 1'b1;

    // Input 1 offers an all-invalid word: consumed, dropped, input 2 next.
    do_reset();
    all_idle();
    RX_SRC_RDY[0] = 1'b1;
    step();
    RX_SRC_RDY[0] = 1'b0;
    set_in(1, 1'b1, 4'h0, 32'hDEADBEEF);
    RX_SRC_RDY[2] = 1'b1;
    step();
    chk("t4_empty_grant", 64'(s_dst), 64'h2);
    RX_SRC_RDY[1] = 1'b0;
    step();
    chk("t4_next_grant", 64'(s_dst), 64'h4);
    chk("t4_no_output", 64'(s_src), 64'd0);
    RX_SRC_RDY[2] = 1'b0;
    step();
    chk("t4_out_src", 64'({s_src, s_sel}), 64'({1'b1, 2'd2}));

    // Reset while a word is held: word discarded, input 0 first afterwards.
    do_reset();
    all_idle();
    TX_DST_RDY = 1'b0;
    RX_SRC_RDY[3] = 1'b1;
    step();
    step();
    chk("t5_held", 64'({s_src, s_dst}), 64'({1'b1, 4'h0}));
    do_reset();
    for (int i = 0; i < N; i++) RX_SRC_RDY[i] = 1'b1;
    step();
    chk("t5_after_reset_src", 64'(s_src), 64'd0);
    chk("t5_after_reset_grant", 64'(s_dst), 64'h1);
    TX_DST_RDY = 1'b1;

    // Randomized traffic.
    do_reset();
    n_in = 0; n_out = 0; n_xfer = 0;
    for (int cyc = 0; cyc < 40000 && n_xfer < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        set_in(i, 1'($urandom_range(0, 3) != 0),
               ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom),
               32'($urandom));
      end
      TX_DST_RDY = 1'($urandom_range(0, 3) != 0);
      step();
    end
    chk("rand_xfer_count_reached", 64'(n_xfer >= 10000), 64'd1);
    all_idle();
    TX_DST_RDY = 1'b1;
    repeat (3) step();
    chk("rand_out_eq_in", 64'(n_out), 64'(n_in));
    for (int i = 0; i < N; i++) chk("rand_sb_empty", 64'(sb[i].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
